// File: rtl/obi_dp_ram_bridge_if.sv
// OBI data-side bus plus RAM port B signals shared by the bridge and its neighbours.
interface obi_dp_ram_bridge_if #(
    parameter int RAM_ADDR_WIDTH = 17
);
    logic                      data_req_i;
    logic                      data_gnt_o;
    logic [31:0]               data_addr_i;
    logic                      data_we_i;
    logic [3:0]                data_be_i;
    logic [31:0]               data_wdata_i;
    logic                      data_rvalid_o;
    logic [31:0]               data_rdata_o;
    logic                      data_err_o;
    logic                      ram_en_o;
    logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
    logic [3:0]                ram_we_o;
    logic [31:0]               ram_din_o;
    logic [31:0]               ram_dout_i;

    modport slave (
        input  data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, ram_dout_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        output ram_en_o, ram_addr_o, ram_we_o, ram_din_o
    );

    modport master (
        output data_req_i, data_addr_i, data_we_i, data_be_i, data_wdata_i, ram_dout_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o,
        input  ram_en_o, ram_addr_o, ram_we_o, ram_din_o
    );
endinterface

// File: rtl/obi_dp_ram_bridge.sv
// OBI data port to byte-enabled RAM port B: single-cycle enables, one-cycle read response,
// window error flagging and optional LFSR-driven grant wait states.
module obi_dp_ram_bridge #(
    parameter int          RAM_ADDR_WIDTH = 17,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter bit          STALL_EN       = 1'b0,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    obi_dp_ram_bridge_if.slave bus
);
    localparam int DATA_W = 32;

    typedef enum logic {ST_READY, ST_WAIT} state_t;

    state_t                    state, state_nxt;
    logic [1:0]                wait_cnt, wait_cnt_nxt;
    logic [15:0]               lfsr;
    logic                      stall_gnt;
    logic                      gnt;
    logic                      fire;
    logic                      in_range;
    logic [RAM_ADDR_WIDTH-1:0] offset;
    logic                      vld_p1;
    logic                      rd_p1;
    logic                      err_p1;

    assign in_range = (bus.data_addr_i >> RAM_ADDR_WIDTH) == (BASE_ADDR >> RAM_ADDR_WIDTH);
    assign offset   = RAM_ADDR_WIDTH'(bus.data_addr_i - BASE_ADDR);

    // Free-running Fibonacci LFSR, taps 16,14,13,11 counted from the output bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_READY;
            wait_cnt <= 2'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        stall_gnt    = 1'b0;
        case (state)
            ST_READY: begin
                if (bus.data_req_i) begin
                    if (lfsr[1:0] == 2'd0) begin
                        stall_gnt = 1'b1;
                    end else begin
                        wait_cnt_nxt = lfsr[1:0];
                        state_nxt    = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 2'd1;
                if (wait_cnt == 2'd1) begin
                    stall_gnt = 1'b1;
                    state_nxt = ST_READY;
                end
            end
            default: state_nxt = ST_READY;
        endcase
    end

    // Grant is held low while reset is asserted so nothing reaches the RAM.
    assign gnt  = bus.data_req_i & !rst_i & (STALL_EN ? stall_gnt : 1'b1);
    assign fire = gnt;

    // Stage p0: grant cycle drives the RAM directly.
    assign bus.data_gnt_o = gnt;
    assign bus.ram_en_o   = fire & in_range;
    assign bus.ram_we_o   = (fire && in_range && bus.data_we_i) ? bus.data_be_i : 4'b0000;
    assign bus.ram_addr_o = fire ? (offset & ~RAM_ADDR_WIDTH'(3)) : '0;
    assign bus.ram_din_o  = fire ? bus.data_wdata_i : '0;

    // Stage p1: response lines up with the RAM's registered read data.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            rd_p1  <= 1'b0;
            err_p1 <= 1'b0;
        end else begin
            vld_p1 <= fire;
            if (fire) begin
                rd_p1  <= !bus.data_we_i;
                err_p1 <= !in_range;
            end
        end
    end

    assign bus.data_rvalid_o = vld_p1;
    assign bus.data_err_o    = vld_p1 & err_p1;
    assign bus.data_rdata_o  = (vld_p1 && rd_p1 && !err_p1) ? bus.ram_dout_i : {DATA_W{1'b0}};

    a_obi_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.data_req_i && !bus.data_gnt_o) |=>
        (bus.data_req_i && $stable(bus.data_addr_i) && $stable(bus.data_we_i) &&
         $stable(bus.data_be_i) && $stable(bus.data_wdata_i)));

endmodule

// File: tb/tb_obi_dp_ram_bridge.sv
// Bench for obi_dp_ram_bridge: one unstalled and one stalled instance, each with a RAM model,
// checked against a word-level memory model and a queue of expected responses.
module tb_obi_dp_ram_bridge;
    localparam int          AW   = 17;
    localparam logic [15:0] SEED = 16'hACE1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic [31:0] mem0 [0:(1<<(AW-2))-1];
    logic [31:0] mem1 [0:(1<<(AW-2))-1];
    logic [31:0] refm [int];
    resp_t       q0 [$];
    resp_t       q1 [$];
    logic [15:0] lfsr_m;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    obi_dp_ram_bridge_if #(.RAM_ADDR_WIDTH(AW)) bus0 ();
    obi_dp_ram_bridge_if #(.RAM_ADDR_WIDTH(AW)) bus1 ();

    obi_dp_ram_bridge #(.RAM_ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .STALL_EN(1'b0), .LFSR_SEED(SEED))
        dut0 (.clk_i(clk), .rst_i(rst0), .bus(bus0));
    obi_dp_ram_bridge #(.RAM_ADDR_WIDTH(AW), .BASE_ADDR(32'h0), .STALL_EN(1'b1), .LFSR_SEED(SEED))
        dut1 (.clk_i(clk), .rst_i(rst1), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // RAM port B models: registered read, byte-enabled write.
    always @(posedge clk) begin
        if (bus0.ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (bus0.ram_we_o[b]) mem0[bus0.ram_addr_o[AW-1:2]][8*b +: 8] <= bus0.ram_din_o[8*b +: 8];
            bus0.ram_dout_i <= mem0[bus0.ram_addr_o[AW-1:2]];
        end
        if (bus1.ram_en_o) begin
            for (int b = 0; b < 4; b++)
                if (bus1.ram_we_o[b]) mem1[bus1.ram_addr_o[AW-1:2]][8*b +: 8] <= bus1.ram_din_o[8*b +: 8];
            bus1.ram_dout_i <= mem1[bus1.ram_addr_o[AW-1:2]];
        end
    end

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        logic [15:0] fb;
        fb = ((x >> 0) ^ (x >> 2) ^ (x >> 3) ^ (x >> 5)) & 16'd1;
        return (x >> 1) | (fb << 15);
    endfunction

    always @(posedge clk or posedge rst1) begin
        if (rst1) lfsr_m <= SEED;
        else      lfsr_m <= lfsr_step(lfsr_m);
    end

    function automatic bit in_win(input logic [31:0] a);
        return a < 32'h0002_0000;
    endfunction

    task automatic model(input int d, input bit we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int unsigned gcyc, output resp_t r);
        int          key;
        logic [31:0] w;
        r.cyc  = gcyc + 1;
        r.err  = !in_win(a);
        r.data = 32'h0;
        if (in_win(a)) begin
            key = d * 65536 + int'(a / 4);
            w   = refm.exists(key) ? refm[key] : 32'h0;
            if (we) begin
                for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
                refm[key] = w;
            end else begin
                r.data = w;
            end
        end
    endtask

    always @(negedge clk) begin
        bit e0, e1;
        while (q0.size() > 0 && q0[0].cyc < cyc) void'(q0.pop_front());
        while (q1.size() > 0 && q1[0].cyc < cyc) void'(q1.pop_front());
        e0 = (q0.size() > 0) && (q0[0].cyc == cyc);
        e1 = (q1.size() > 0) && (q1[0].cyc == cyc);
        chk("rvalid0", bus0.data_rvalid_o, e0);
        chk("rvalid1", bus1.data_rvalid_o, e1);
        if (e0) begin
            chk("rdata0", bus0.data_rdata_o, q0[0].data);
            chk("err0", bus0.data_err_o, q0[0].err);
            void'(q0.pop_front());
        end else begin
            chk("rdata0_idle", bus0.data_rdata_o, 32'h0);
            chk("err0_idle", bus0.data_err_o, 1'b0);
        end
        if (e1) begin
            chk("rdata1", bus1.data_rdata_o, q1[0].data);
            chk("err1", bus1.data_err_o, q1[0].err);
            void'(q1.pop_front());
        end
    end

    task automatic issue0(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        resp_t r;
        bit    inw;
        inw = in_win(a);
        bus0.data_req_i = 1'b1; bus0.data_we_i = we; bus0.data_addr_i = a;
        bus0.data_be_i = be;    bus0.data_wdata_i = wd;
        @(negedge clk);
        chk("gnt0", bus0.data_gnt_o, 1'b1);
        chk("ram_en0", bus0.ram_en_o, inw);
        chk("ram_we0", bus0.ram_we_o, (we && inw) ? be : 4'b0000);
        chk("ram_addr0", bus0.ram_addr_o, a & 32'h0001_FFFC);
        chk("ram_din0", bus0.ram_din_o, wd);
        model(0, we, a, be, wd, cyc, r);
        q0.push_back(r);
        @(posedge clk); #1;
    endtask

    task automatic idle0(input int n);
        bus0.data_req_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("gnt0_idle", bus0.data_gnt_o, 1'b0);
            chk("ram_en0_idle", bus0.ram_en_o, 1'b0);
            chk("ram_we0_idle", bus0.ram_we_o, 4'b0000);
            @(posedge clk); #1;
        end
    endtask

    task automatic issue1(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        resp_t r;
        bit    got;
        int    d;
        got = 1'b0;
        d   = 0;
        bus1.data_req_i = 1'b1; bus1.data_we_i = we; bus1.data_addr_i = a;
        bus1.data_be_i = be;    bus1.data_wdata_i = wd;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (k == 0) d = int'(lfsr_m & 16'd3);
            chk("gnt1", bus1.data_gnt_o, k == d);
            if (bus1.data_gnt_o) begin
                got = 1'b1;
                chk("ram_en1", bus1.ram_en_o, in_win(a));
                model(1, we, a, be, wd, cyc, r);
                q1.push_back(r);
            end
            @(posedge clk); #1;
        end
        if (!got) begin
            chk("gnt1_timeout", 1'b0, 1'b1);
            bus1.data_req_i = 1'b0;
        end
    endtask

    task automatic idle1(input int n);
        bus1.data_req_i = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return 32'h0002_0000 + ($urandom_range(0, 255) << 2);
        return ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < (1 << (AW - 2)); i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
        bus0.data_req_i = 1'b1; bus0.data_we_i = 1'b1; bus0.data_addr_i = 32'h100;
        bus0.data_be_i = 4'hF;  bus0.data_wdata_i = 32'h1234_5678;
        bus1.data_req_i = 1'b0; bus1.data_we_i = 1'b0; bus1.data_addr_i = 32'h0;
        bus1.data_be_i = 4'h0;  bus1.data_wdata_i = 32'h0;

        // Reset state, with a request pending on dut0.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", bus0.data_gnt_o, 1'b0);
        chk("rst_ram_en", bus0.ram_en_o, 1'b0);
        chk("rst_ram_we", bus0.ram_we_o, 4'b0000);
        chk("rst_ram_din", bus0.ram_din_o, 32'h0);
        bus0.data_req_i = 1'b0;
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0;

        // Directed: write/read, byte merge, back-to-back, out-of-window, be=0000, misaligned.
        issue0(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF); idle0(1);
        issue0(1'b0, 32'h100, 4'hF, 32'h0);
        issue0(1'b1, 32'h040, 4'hF, 32'h1122_3344);
        issue0(1'b1, 32'h040, 4'h5, 32'hAABB_CCDD);
        issue0(1'b0, 32'h040, 4'hF, 32'h0); idle0(1);
        issue0(1'b0, 32'h000, 4'hF, 32'h0);
        issue0(1'b0, 32'h004, 4'hF, 32'h0);
        issue0(1'b0, 32'h008, 4'hF, 32'h0); idle0(1);
        issue0(1'b0, 32'h0002_0000, 4'hF, 32'h0);
        issue0(1'b0, 32'h100, 4'hF, 32'h0); idle0(1);
        issue0(1'b1, 32'h040, 4'h0, 32'hFFFF_FFFF);
        issue0(1'b0, 32'h043, 4'hF, 32'h0); idle0(1);

        for (int n = 0; n < 30; n++) begin
            issue0(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
            if ($urandom_range(0, 1) != 0) idle0(1);
        end
        idle0(1);

        // Reset in the cycle after a read grant: the response is dropped.
        issue0(1'b0, 32'h100, 4'hF, 32'h0);
        rst0 = 1'b1;
        q0.delete();
        bus0.data_req_i = 1'b1; bus0.data_we_i = 1'b1; bus0.data_addr_i = 32'h104;
        bus0.data_be_i = 4'hF;  bus0.data_wdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rst_mid_gnt", bus0.data_gnt_o, 1'b0);
        chk("rst_mid_ram_en", bus0.ram_en_o, 1'b0);
        chk("rst_mid_ram_we", bus0.ram_we_o, 4'b0000);
        chk("rst_mid_ram_addr", bus0.ram_addr_o, 32'h0);
        chk("rst_mid_ram_din", bus0.ram_din_o, 32'h0);
        @(posedge clk); #1;
        rst0 = 1'b0;
        bus0.data_req_i = 1'b0;
        idle0(1);
        issue0(1'b0, 32'h100, 4'hF, 32'h0); idle0(2);

        // Stalled instance: random traffic against the grant-delay and data model.
        for (int n = 0; n < 50; n++) begin
            issue1(1'($urandom_range(0, 1)), rand_addr(), 4'($urandom), $urandom);
            if ($urandom_range(0, 1) != 0) idle1($urandom_range(1, 2));
        end
        idle1(3);
        idle0(1);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
